onchip_memory_arbiter: RTL and testbench
========================================

Name: onchip_memory_arbiter

Overview:
Two-master arbiter sharing one single-port on-chip RAM (12-bit word address, 32-bit data, 4 byte enables, 1-cycle read latency). It presents two Avalon-MM slave ports with waitrequest and readdatavalid, for example a CPU data master and a DMA engine. It drives one memory-side port with address, byteenable, chipselect, write, writedata and clken. It sits between the system interconnect and the RAM block.

Parameters:
ADDR_W, 12, word address width
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)
READ_LATENCY, 1, memory read latency in clocks; legal values 1 and 2 (2 = registered RAM output)
LOCK_MAX, 4, maximum consecutive locked grants before forced hand-over (used only with MEMARB_LOCK_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  port 0 word address
m0_byteenable  in  BE_W  port 0 byte enables
m0_read  in  1  port 0 read request
m0_write  in  1  port 0 write request
m0_writedata  in  DATA_W  port 0 write data
m0_waitrequest  out  1  port 0 stall
m0_readdata  out  DATA_W  port 0 read data
m0_readdatavalid  out  1  port 0 read data valid
m0_lock  in  1  port 0 keep grant (MEMARB_LOCK_EN only)
m1_*  same set as m0_*  port 1
mem_address  out  ADDR_W  RAM address
mem_byteenable  out  BE_W  RAM byte enables
mem_chipselect  out  1  RAM access strobe
mem_write  out  1  RAM write
mem_writedata  out  DATA_W  RAM write data
mem_clken  out  1  RAM clock enable
mem_readdata  in  DATA_W  RAM read data

Behaviour:
- Request on a port: mX_read | mX_write. If both are high on the same port, it is a write; the read is ignored.
- Arbitration is combinational each cycle. One transfer is accepted per cycle, when the granted port's request is high and its waitrequest is 0.
- Non-granted requesting port sees waitrequest=1. Idle port sees waitrequest=0 outside reset.
- Round-robin: register last_grant, reset value 1, so m0 wins the first contention. If both ports request, the port that is not last_grant wins. If only one port requests, it wins. last_grant updates only on accept.
- Memory side carries the winner's address, byteenable and writedata.
  - mem_chipselect = accept.
  - mem_write = accept & write.
  - When idle: mem_chipselect=0, mem_write=0, address/data muxed from m0.
- mem_clken = 1 whenever reset_n is high, 0 while in reset.
- Read tag pipeline: shift register READ_LATENCY deep holding {valid, port_id}, loaded on every accepted read.
  - mX_readdatavalid is asserted exactly READ_LATENCY cycles after accept, for the tagged port only.
  - mX_readdata = mem_readdata for both ports. Valid only with readdatavalid.
- Back-to-back reads from either port are pipelined with no bubbles. Writes have no response.
- Reset values while reset_n=0:
  - both waitrequest=1
  - both readdatavalid=0
  - mem_chipselect=0, mem_write=0, mem_clken=0
  - tag pipeline cleared
  - last_grant=1
- Reset asserted mid-operation: in-flight reads are discarded. No readdatavalid is issued after release.
- First cycle after reset_n deasserts: normal arbitration.

Optional Feature:
MEMARB_LOCK_EN
- Defined:
  - An accept with mX_lock=1 pins the grant to that port. While pinned, the other port waits even if round-robin would favour it.
  - The pin releases on an accept with lock=0, or when the locked port stops requesting.
  - A lock counter counts consecutive locked accepts while the other port requests. When it reaches LOCK_MAX, the next cycle grants the other port (one transfer), then the counter clears.
  - The counter resets to 0.
- Undefined: m*_lock inputs are ignored and left unconnected internally; pure round-robin; no counter logic.

Test Plan:
1. Hold reset_n=0 with requests active -> m0/m1_waitrequest=1, readdatavalid=0, mem_chipselect=0, mem_clken=0. Release -> m0 read granted on the first cycle.
2. m0 write addr 0x123 data 0xDEADBEEF be 0xF, then m0 read 0x123 -> m0_readdatavalid exactly 1 cycle after accept (READ_LATENCY=1) with 0xDEADBEEF. m1_readdatavalid stays 0.
3. m1 write 0x0FF data 0x11223344 be 0x3 over existing 0xDEADBEEF, then read -> 0xDEAD3344.
4. Both ports issue continuous reads (m0 at 0x000.., m1 at 0x800..) -> accepts alternate m0,m1,m0,m1. Each readdatavalid goes to the correct port with the correct data, no bubbles. Repeat with READ_LATENCY=2 -> valid 2 cycles after accept.
5. Assert reset_n=0 one cycle after an m0 read accept -> no m0_readdatavalid after release. Tag pipeline empty.
6. MEMARB_LOCK_EN, LOCK_MAX=4: m0 locked reads while m1 requests -> 4 m0 accepts, 1 m1 accept, 4 m0 accepts. Without the macro -> strict alternation.

Source files
------------

// File: rtl/onchip_memory_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port on-chip RAM with round-robin grant.
// Optional grant locking with forced hand-over is enabled by defining MEMARB_LOCK_EN.
module onchip_memory_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BE_W         = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LOCK_MAX     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              m1_lock,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0;
  logic req1;
  logic rr_grant;
  logic grant;
  logic accept;
  logic wr_sel;
  logic last_grant;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_port;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign accept = reset_n & (req0 | req1);
  assign wr_sel = grant ? m1_write : m0_write;

`ifdef MEMARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  logic             pinned;
  logic             lock_port;
  logic             lock_req;
  logic             other_req;
  logic             lock_sel;
  logic             force_hand;
  logic [CNT_W-1:0] lock_cnt;

  assign lock_req   = lock_port ? req1 : req0;
  assign other_req  = lock_port ? req0 : req1;
  assign force_hand = (lock_cnt == CNT_W'(LOCK_MAX)) & other_req;
  assign lock_sel   = grant ? m1_lock : m0_lock;

  // Pin tracking and count of consecutive locked accepts while the other port waits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pinned    <= 1'b0;
      lock_port <= 1'b0;
      lock_cnt  <= '0;
    end else if (accept) begin
      pinned    <= lock_sel;
      lock_port <= grant;
      if (!force_hand && lock_sel && (grant ? req0 : req1))
        lock_cnt <= (pinned && (lock_port == grant)) ? lock_cnt + CNT_W'(1) : CNT_W'(1);
      else
        lock_cnt <= '0;
    end else begin
      // No accept means the pinned port stopped requesting
      pinned <= 1'b0;
    end
  end
`else
  localparam int unsigned unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

  // Round-robin winner, optionally overridden by lock pinning or forced hand-over
  always_comb begin
    rr_grant = (req0 & req1) ? ~last_grant : (req1 & ~req0);
    grant    = rr_grant;
`ifdef MEMARB_LOCK_EN
    if (force_hand)
      grant = ~lock_port;
    else if (pinned && lock_req)
      grant = lock_port;
`endif
  end

  // Grant history and read tag pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      tag_vld    <= '0;
      tag_port   <= '0;
    end else begin
      if (accept)
        last_grant <= grant;
      tag_vld[0]  <= accept & ~wr_sel;
      tag_port[0] <= grant;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_port[i] <= tag_port[i-1];
      end
    end
  end

  assign m0_waitrequest   = ~reset_n | (req0 & grant);
  assign m1_waitrequest   = ~reset_n | (req1 & ~grant);
  assign m0_readdatavalid = tag_vld[READ_LATENCY-1] & ~tag_port[READ_LATENCY-1];
  assign m1_readdatavalid = tag_vld[READ_LATENCY-1] & tag_port[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  assign mem_address    = grant ? m1_address : m0_address;
  assign mem_byteenable = grant ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant ? m1_writedata : m0_writedata;
  assign mem_chipselect = accept;
  assign mem_write      = accept & wr_sel;
  assign mem_clken      = reset_n;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 2) share stimulus, each with its own RAM model.
module tb_onchip_memory_arbiter;

  logic        clk;
  logic        reset_n;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write, m0_lock, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;

  logic        a_m0_waitrequest, a_m0_readdatavalid, a_m1_waitrequest, a_m1_readdatavalid;
  logic [31:0] a_m0_readdata, a_m1_readdata, a_mem_writedata, a_mem_readdata;
  logic [11:0] a_mem_address;
  logic [3:0]  a_mem_byteenable;
  logic        a_mem_chipselect, a_mem_write, a_mem_clken;

  logic        b_m0_waitrequest, b_m0_readdatavalid, b_m1_waitrequest, b_m1_readdatavalid;
  logic [31:0] b_m0_readdata, b_m1_readdata, b_mem_writedata, b_mem_readdata;
  logic [11:0] b_mem_address;
  logic [3:0]  b_mem_byteenable;
  logic        b_mem_chipselect, b_mem_write, b_mem_clken;

  int errors = 0;
  int checks = 0;

  onchip_memory_arbiter #(.READ_LATENCY(1)) u_a (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_m0_waitrequest),
    .m0_readdata(a_m0_readdata), .m0_readdatavalid(a_m0_readdatavalid), .m0_lock(m0_lock),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_m1_waitrequest),
    .m1_readdata(a_m1_readdata), .m1_readdatavalid(a_m1_readdatavalid), .m1_lock(m1_lock),
    .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
    .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
    .mem_writedata(a_mem_writedata), .mem_clken(a_mem_clken), .mem_readdata(a_mem_readdata)
  );

  onchip_memory_arbiter #(.READ_LATENCY(2)) u_b (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_m0_waitrequest),
    .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid), .m0_lock(m0_lock),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_m1_waitrequest),
    .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid), .m1_lock(m1_lock),
    .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
    .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
    .mem_writedata(b_mem_writedata), .mem_clken(b_mem_clken), .mem_readdata(b_mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten RAM words read back as a pattern derived from their address
  function automatic logic [31:0] pat(input logic [11:0] a);
    return {8'hA5, 4'h0, a, a[7:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [31:0]   ram_a [4096];
  logic [31:0]   ram_b [4096];
  logic [4095:0] wr_a = '0;
  logic [4095:0] wr_b = '0;
  logic [31:0]   cur_a, cur_b, rd_b0;

  assign cur_a = wr_a[a_mem_address] ? ram_a[a_mem_address] : pat(a_mem_address);
  assign cur_b = wr_b[b_mem_address] ? ram_b[b_mem_address] : pat(b_mem_address);

  always @(posedge clk) begin
    if (a_mem_chipselect) begin
      if (a_mem_write) begin
        ram_a[a_mem_address] <= merge(cur_a, a_mem_writedata, a_mem_byteenable);
        wr_a[a_mem_address]  <= 1'b1;
      end else begin
        a_mem_readdata <= cur_a;
      end
    end
  end

  always @(posedge clk) begin
    if (b_mem_chipselect) begin
      if (b_mem_write) begin
        ram_b[b_mem_address] <= merge(cur_b, b_mem_writedata, b_mem_byteenable);
        wr_b[b_mem_address]  <= 1'b1;
      end else begin
        rd_b0 <= cur_b;
      end
    end
    b_mem_readdata <= rd_b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        h_port [8];
  logic [11:0] h_addr [8];
  logic [11:0] a0, a1;
  logic        w;
  logic        exp_seq [9];

  initial begin
    reset_n = 1'b0;
    m0_address = 12'h010; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0;
    m0_writedata = '0; m0_lock = 1'b0;
    m1_address = 12'h810; m1_byteenable = 4'hF; m1_read = 1'b1; m1_write = 1'b0;
    m1_writedata = '0; m1_lock = 1'b0;

    // Reset with requests active
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wait0", a_m0_waitrequest, 1);
    chk("rst_wait1", a_m1_waitrequest, 1);
    chk("rst_rdv0", a_m0_readdatavalid, 0);
    chk("rst_rdv1", b_m1_readdatavalid, 0);
    chk("rst_cs", a_mem_chipselect, 0);
    chk("rst_we", a_mem_write, 0);
    chk("rst_clken", a_mem_clken, 0);
    chk("rst_clken_b", b_mem_clken, 0);

    reset_n = 1'b1;
    #1;
    chk("rel_wait0", a_m0_waitrequest, 0);
    chk("rel_wait1", a_m1_waitrequest, 1);
    chk("rel_cs", a_mem_chipselect, 1);
    chk("rel_addr", a_mem_address, 12'h010);
    chk("rel_clken", a_mem_clken, 1);
    tick();
    m0_read = 1'b0; m1_read = 1'b0;
    #1;
    chk("t1_rdv0", a_m0_readdatavalid, 1);
    chk("t1_data", a_m0_readdata, pat(12'h010));
    chk("t1_rdv1", a_m1_readdatavalid, 0);
    chk("t1_b_early", b_m0_readdatavalid, 0);
    chk("idle_wait0", a_m0_waitrequest, 0);
    chk("idle_wait1", a_m1_waitrequest, 0);
    chk("idle_cs", a_mem_chipselect, 0);
    tick();
    chk("t1_b_rdv0", b_m0_readdatavalid, 1);
    chk("t1_b_data", b_m0_readdata, pat(12'h010));
    chk("t1_a_done", a_m0_readdatavalid, 0);

    // m0 write then read back
    m0_write = 1'b1; m0_address = 12'h123; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    #1;
    chk("t2_we", a_mem_write, 1);
    chk("t2_wd", a_mem_writedata, 32'hDEADBEEF);
    chk("t2_addr", a_mem_address, 12'h123);
    chk("t2_be", a_mem_byteenable, 4'hF);
    tick();
    m0_write = 1'b0; m0_read = 1'b1;
    #1;
    chk("t2_rd_we", a_mem_write, 0);
    chk("t2_rd_cs", a_mem_chipselect, 1);
    tick();
    m0_read = 1'b0;
    chk("t2_rdv0", a_m0_readdatavalid, 1);
    chk("t2_data", a_m0_readdata, 32'hDEADBEEF);
    chk("t2_rdv1", a_m1_readdatavalid, 0);
    tick();
    chk("t2_b_rdv0", b_m0_readdatavalid, 1);
    chk("t2_b_data", b_m0_readdata, 32'hDEADBEEF);

    // m1 partial write; read+write together counts as a write
    m1_write = 1'b1; m1_address = 12'h0FF; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
    tick();
    m1_read = 1'b1; m1_writedata = 32'h11223344; m1_byteenable = 4'h3;
    #1;
    chk("t3_we", a_mem_write, 1);
    chk("t3_be", a_mem_byteenable, 4'h3);
    chk("t3_addr", a_mem_address, 12'h0FF);
    chk("t3_wait1", a_m1_waitrequest, 0);
    tick();
    m1_write = 1'b0;
    chk("t3_no_resp", a_m1_readdatavalid, 0);
    tick();
    m1_read = 1'b0;
    chk("t3_rdv1", a_m1_readdatavalid, 1);
    chk("t3_data", a_m1_readdata, 32'hDEAD3344);
    chk("t3_rdv0", a_m0_readdatavalid, 0);
    tick();

    // Continuous reads from both ports alternate with no bubbles
    a0 = 12'h000; a1 = 12'h800;
    for (int k = 0; k < 8; k++) begin
      w = k[0];
      m0_read = 1'b1; m0_address = a0;
      m1_read = 1'b1; m1_address = a1;
      #1;
      chk("t4_wait0", a_m0_waitrequest, w);
      chk("t4_wait1", a_m1_waitrequest, !w);
      chk("t4_addr", a_mem_address, w ? a1 : a0);
      tick();
      h_port[k] = w;
      h_addr[k] = w ? a1 : a0;
      if (w) a1 = a1 + 12'd1;
      else a0 = a0 + 12'd1;
      chk("t4_a_rdv0", a_m0_readdatavalid, !w);
      chk("t4_a_rdv1", a_m1_readdatavalid, w);
      chk("t4_a_data", a_mem_readdata, pat(h_addr[k]));
      if (k == 0) begin
        chk("t4_b_rdv0_first", b_m0_readdatavalid, 0);
        chk("t4_b_rdv1_first", b_m1_readdatavalid, 0);
      end else begin
        chk("t4_b_rdv0", b_m0_readdatavalid, !h_port[k-1]);
        chk("t4_b_rdv1", b_m1_readdatavalid, h_port[k-1]);
        chk("t4_b_data", b_mem_readdata, pat(h_addr[k-1]));
      end
    end
    m0_read = 1'b0; m1_read = 1'b0;
    tick();
    chk("t4_b_last_rdv1", b_m1_readdatavalid, h_port[7]);
    chk("t4_b_last_data", b_m1_readdata, pat(h_addr[7]));
    chk("t4_a_drain0", a_m0_readdatavalid, 0);
    chk("t4_a_drain1", a_m1_readdatavalid, 0);

    // Reset right after a read accept discards the in-flight read
    m0_read = 1'b1; m0_address = 12'h200;
    tick();
    m0_read = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_rdv_a", a_m0_readdatavalid, 0);
    chk("t5_rst_rdv_b", b_m0_readdatavalid, 0);
    chk("t5_rst_wait", a_m0_waitrequest, 1);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_b_rdv0", b_m0_readdatavalid, 0);
      chk("t5_b_rdv1", b_m1_readdatavalid, 0);
      chk("t5_a_rdv0", a_m0_readdatavalid, 0);
    end

    // Locked m0 reads against m1 requests
`ifdef MEMARB_LOCK_EN
    for (int k = 0; k < 9; k++) exp_seq[k] = (k == 4);
`else
    for (int k = 0; k < 9; k++) exp_seq[k] = (k % 2 == 1);
`endif
    m0_read = 1'b1; m0_lock = 1'b1; m0_address = 12'h300;
    m1_read = 1'b1; m1_address = 12'h900;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("t6_wait0", a_m0_waitrequest, exp_seq[k]);
      chk("t6_wait1", a_m1_waitrequest, !exp_seq[k]);
      tick();
    end
    m0_read = 1'b0; m1_read = 1'b0; m0_lock = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
